// File: rtl/router_pkg.sv
// ============================================================================
// Module      : router_pkg
// Description : Shared constants, FSM state encoding and header helper for
//               the router packet transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package router_pkg;

    localparam int MAX_PLD_LEN  = 63;
    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;

    localparam logic [1:0] ADDR_INVALID = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_PAYLOAD = 3'd2,
        S_PARITY  = 3'd3,
        S_CHECK   = 3'd4,
        S_DONE    = 3'd5
    } tx_state_e;

    function automatic logic [7:0] make_header(input logic [5:0] len,
                                               input logic [1:0] addr);
        logic [7:0] hdr;
        hdr                           = '0;
        hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
        hdr[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
        return hdr;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pkt_buffer.sv
// ============================================================================
// Module      : pkt_buffer
// Description : 64x8 payload register file with write pointer/count, read
//               pointer and full flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pkt_buffer
    import router_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_inc,
    input  logic       clr,
    output logic [7:0] rd_data,
    output logic [5:0] count,
    output logic [5:0] rd_ptr,
    output logic       full
);

    logic [7:0] mem_q [64];
    logic [5:0] wr_ptr_q;
    logic [5:0] count_q;
    logic [5:0] rd_ptr_q;
    logic       w_wr;

    assign full    = (count_q == 6'(MAX_PLD_LEN));
    assign w_wr    = wr_en && !full;
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign rd_ptr  = rd_ptr_q;

    // Storage is not reset: contents are meaningless once count is cleared.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            rd_ptr_q <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_wr) begin
                wr_ptr_q <= wr_ptr_q + 6'd1;
                count_q  <= count_q + 6'd1;
            end
            if (rd_inc) begin
                rd_ptr_q <= rd_ptr_q + 6'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/router_pkt_tx.sv
// ============================================================================
// Module      : router_pkt_tx
// Description : Buffers a payload and transmits header, payload and parity to
//               a router, then samples the router's error line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_pkt_tx
    import router_pkg::*;
#(
    parameter int CHECK_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       pld_wr,
    input  logic [7:0] pld_data,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic       busy,
    input  logic       err,
    output logic [7:0] data_out,
    output logic       pkt_valid,
    output logic       tx_active,
    output logic       buf_full,
    output logic       pkt_done,
    output logic       err_flag
);

    localparam int              CW       = (CHECK_CYCLES > 1) ? $clog2(CHECK_CYCLES) : 1;
    localparam logic [CW-1:0]   CHK_LAST = CW'(CHECK_CYCLES - 1);

    tx_state_e     state_q, state_d;
    logic [1:0]    addr_q, addr_d;
    logic [7:0]    parity_q, parity_d;
    logic [CW-1:0] chk_q, chk_d;
    logic          err_flag_q, err_flag_d;

    logic          w_wr_en;
    logic          w_rd_inc;
    logic          w_clr;
    logic [7:0]    w_rd_data;
    logic [5:0]    w_count;
    logic [5:0]    w_rd_ptr;
    logic [5:0]    w_len;
    logic          w_start_ok;
    logic [7:0]    w_header;

    pkt_buffer u_buf (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (w_wr_en),
        .wr_data (pld_data),
        .rd_inc  (w_rd_inc),
        .clr     (w_clr),
        .rd_data (w_rd_data),
        .count   (w_count),
        .rd_ptr  (w_rd_ptr),
        .full    (buf_full)
    );

    assign w_wr_en = pld_wr && (state_q == S_IDLE) && !buf_full;
    // A byte written in the start cycle is part of the packet being launched.
    assign w_len      = w_count + {5'd0, w_wr_en};
    assign w_start_ok = start && (state_q == S_IDLE) && (w_len != 6'd0)
                        && (dest_addr != ADDR_INVALID);
    assign w_header   = make_header(w_count, addr_q);
    assign tx_active  = (state_q != S_IDLE);
    assign err_flag   = err_flag_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            parity_q   <= '0;
            chk_q      <= '0;
            err_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            parity_q   <= parity_d;
            chk_q      <= chk_d;
            err_flag_q <= err_flag_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        parity_d   = parity_q;
        chk_d      = chk_q;
        err_flag_d = err_flag_q;
        w_rd_inc   = 1'b0;
        w_clr      = 1'b0;
        data_out   = 8'd0;
        pkt_valid  = 1'b0;
        pkt_done   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (w_start_ok) begin
                    state_d    = S_HEADER;
                    addr_d     = dest_addr;
                    parity_d   = 8'd0;
                    err_flag_d = 1'b0;
                end
            end
            S_HEADER: begin
                data_out  = w_header;
                pkt_valid = 1'b1;
                if (!busy) begin
                    parity_d = parity_q ^ w_header;
                    state_d  = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                data_out  = w_rd_data;
                pkt_valid = 1'b1;
                if (!busy) begin
                    parity_d = parity_q ^ w_rd_data;
                    w_rd_inc = 1'b1;
                    if (w_rd_ptr == (w_count - 6'd1)) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                data_out = parity_q;
                if (!busy) begin
                    state_d = S_CHECK;
                    chk_d   = '0;
                end
            end
            S_CHECK: begin
                if (err) begin
                    err_flag_d = 1'b1;
                end
                if (chk_q == CHK_LAST) begin
                    state_d = S_DONE;
                end else begin
                    chk_d = chk_q + CW'(1);
                end
            end
            S_DONE: begin
                pkt_done = 1'b1;
                w_clr    = 1'b1;
                parity_d = 8'd0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
// ============================================================================
// Module      : tb_router_pkt_tx
// Description : Scoreboard bench for router_pkt_tx with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_router_pkt_tx;

    logic       clk = 1'b0;
    logic       rstn;
    logic       pld_wr;
    logic [7:0] pld_data;
    logic       start;
    logic [1:0] dest_addr;
    logic       busy;
    logic       err;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       tx_active;
    logic       buf_full;
    logic       pkt_done;
    logic       err_flag;

    router_pkt_tx #(.CHECK_CYCLES(3)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .pld_wr    (pld_wr),
        .pld_data  (pld_data),
        .start     (start),
        .dest_addr (dest_addr),
        .busy      (busy),
        .err       (err),
        .data_out  (data_out),
        .pkt_valid (pkt_valid),
        .tx_active (tx_active),
        .buf_full  (buf_full),
        .pkt_done  (pkt_done),
        .err_flag  (err_flag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       v;
        logic       hdr;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mq[$];
    int         checks = 0;
    int         errors = 0;
    logic       mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares presented bytes against the scoreboard and tracks
    // the error-sampling window that follows each parity byte.
    int   chk_ph  = 0;
    logic exp_err = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && rstn) begin
                if (chk_ph != 0) begin
                    if (chk_ph <= 3) begin
                        exp_err = exp_err | err;
                        chk("pkt_done_early", {31'd0, pkt_done}, 32'd0);
                        chk_ph++;
                    end else begin
                        chk("pkt_done", {31'd0, pkt_done}, 32'd1);
                        chk("err_flag", {31'd0, err_flag}, {31'd0, exp_err});
                        chk_ph = 0;
                    end
                end else if (pkt_done) begin
                    chk("pkt_done_unexpected", 32'd1, 32'd0);
                end

                if (pkt_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_byte", {24'd0, data_out}, 32'hFFFF_FFFF);
                    end else begin
                        e = sb[0];
                        chk(busy ? "held_byte" : "byte", {24'd0, data_out}, {24'd0, e.d});
                        chk("byte_valid_kind", {31'd0, e.v}, 32'd1);
                        if (!busy) begin
                            if (e.hdr) chk("err_flag_cleared", {31'd0, err_flag}, 32'd0);
                            void'(sb.pop_front());
                        end
                    end
                end else if (tx_active && sb.size() != 0 && !sb[0].v) begin
                    chk("parity", {24'd0, data_out}, {24'd0, sb[0].d});
                    if (!busy) begin
                        void'(sb.pop_front());
                        chk_ph  = 1;
                        exp_err = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wr(input logic [7:0] d);
        pld_wr   = 1'b1;
        pld_data = d;
        if (mq.size() < 63) mq.push_back(d);
        @(posedge clk); #1;
        pld_wr = 1'b0;
    endtask

    task automatic send(input logic [1:0] dest, input bit ewr, input logic [7:0] ed,
                        input int stall_at, input bit rnd);
        exp_t       e;
        logic [7:0] par;
        bit         acc;
        bit         done;
        int         i;
        int         streak;
        start     = 1'b1;
        dest_addr = dest;
        if (ewr) begin
            pld_wr   = 1'b1;
            pld_data = ed;
            if (mq.size() < 63) mq.push_back(ed);
        end
        acc = (mq.size() != 0) && (dest != 2'd3);
        if (acc) begin
            par   = 8'((mq.size() << 2) | int'(dest));
            e.d   = par; e.v = 1'b1; e.hdr = 1'b1;
            sb.push_back(e);
            foreach (mq[k]) begin
                par   = par ^ mq[k];
                e.d   = mq[k]; e.v = 1'b1; e.hdr = 1'b0;
                sb.push_back(e);
            end
            e.d = par; e.v = 1'b0; e.hdr = 1'b0;
            sb.push_back(e);
            mq.delete();
        end
        @(posedge clk); #1;
        start  = 1'b0;
        pld_wr = 1'b0;
        if (!acc) begin
            repeat (4) begin
                @(negedge clk);
                chk("ignored_start_active", {31'd0, tx_active}, 32'd0);
                chk("ignored_start_valid", {31'd0, pkt_valid}, 32'd0);
            end
            @(posedge clk); #1;
            return;
        end
        i = 0; done = 1'b0; streak = 0;
        while (!done && i < 4000) begin
            if (rnd && streak == 0 && $urandom_range(0, 39) == 0) streak = 12;
            if (stall_at >= 0 && i >= stall_at && i < stall_at + 4) busy = 1'b1;
            else if (streak > 0) begin busy = 1'b1; streak--; end
            else busy = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
            err      = rnd ? ($urandom_range(0, 5) == 0) : 1'b0;
            pld_wr   = ($urandom_range(0, 3) == 0);
            pld_data = 8'($urandom);
            @(negedge clk);
            if (pkt_done) done = 1'b1;
            @(posedge clk); #1;
            i++;
        end
        busy = 1'b0; err = 1'b0; pld_wr = 1'b0;
        if (!done) chk("pkt_done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        rstn = 1'b0; pld_wr = 1'b0; pld_data = '0; start = 1'b0;
        dest_addr = '0; busy = 1'b0; err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data_out", {24'd0, data_out}, 32'd0);
        chk("rst_pkt_valid", {31'd0, pkt_valid}, 32'd0);
        chk("rst_tx_active", {31'd0, tx_active}, 32'd0);
        chk("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
        chk("rst_err_flag", {31'd0, err_flag}, 32'd0);
        chk("rst_buf_full", {31'd0, buf_full}, 32'd0);
        @(posedge clk); #1;
        rstn   = 1'b1;
        mon_en = 1'b1;

        wr(8'h11); wr(8'h22); wr(8'h33);
        send(2'd1, 1'b0, 8'h00, -1, 1'b0);
        wr(8'h11); wr(8'h22); wr(8'h33);
        send(2'd1, 1'b0, 8'h00, 2, 1'b0);

        send(2'd0, 1'b0, 8'h00, -1, 1'b0);
        wr(8'h5A);
        send(2'd3, 1'b0, 8'h00, -1, 1'b0);
        send(2'd2, 1'b0, 8'h00, -1, 1'b1);

        for (int k = 0; k < 63; k++) wr(8'($urandom));
        chk("buf_full_63", {31'd0, buf_full}, 32'd1);
        wr(8'hEE);
        chk("buf_full_after_drop", {31'd0, buf_full}, 32'd1);
        send(2'd2, 1'b0, 8'h00, -1, 1'b1);
        chk("buf_empty_after_pkt", {31'd0, buf_full}, 32'd0);

        send(2'd1, 1'b1, 8'hA5, -1, 1'b1);

        for (int p = 0; p < 20; p++) begin
            n = $urandom_range(0, 20);
            for (int k = 0; k < n; k++) wr(8'($urandom));
            send(2'($urandom), 1'($urandom), 8'($urandom), -1, 1'b1);
        end
        if (mq.size() != 0) send(2'd0, 1'b0, 8'h00, -1, 1'b1);

        mon_en = 1'b0;
        for (int k = 0; k < 8; k++) wr(8'(k + 1));
        start = 1'b1; dest_addr = 2'd0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, pkt_valid}, 32'd0);
        chk("rst_mid_data", {24'd0, data_out}, 32'd0);
        chk("rst_mid_active", {31'd0, tx_active}, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        mq.delete();
        mon_en = 1'b1;
        chk("rst_mid_buf_full", {31'd0, buf_full}, 32'd0);
        send(2'd0, 1'b0, 8'h00, -1, 1'b0);
        wr(8'h01); wr(8'h02);
        send(2'd2, 1'b0, 8'h00, -1, 1'b0);

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
